// File: rtl/router_pkg.sv
// Shared router types and field positions.
//   flit_t        : 64-bit flit word
//   flit_type_e   : flit type encoding in bits [63:62]
//   ctrl_state_e  : input-port controller FSM states
//   N/E/S/W/L     : bit index of each output port in a one-hot request vector
package router_pkg;

    typedef logic [63:0] flit_t;

    typedef enum logic [1:0] {
        FlitBody   = 2'b00,
        FlitHead   = 2'b01,
        FlitTail   = 2'b10,
        FlitSingle = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StActive
    } ctrl_state_e;

    localparam int unsigned TYPE_HI = 63;
    localparam int unsigned TYPE_LO = 62;
    localparam int unsigned DX_HI   = 61;
    localparam int unsigned DX_LO   = 58;
    localparam int unsigned DY_HI   = 57;
    localparam int unsigned DY_LO   = 54;

    localparam int unsigned N         = 0;
    localparam int unsigned E         = 1;
    localparam int unsigned S         = 2;
    localparam int unsigned W         = 3;
    localparam int unsigned L         = 4;
    localparam int unsigned NUM_PORTS = 5;

endpackage

// File: rtl/xy_route_compute.sv
// Combinational dimension-ordered (X first, then Y) route computation.
// Ports:
//   dest_x_i : destination X coordinate from the head flit
//   dest_y_i : destination Y coordinate from the head flit
//   route_o  : one-hot output port {L,W,S,E,N}
module xy_route_compute
    import router_pkg::*;
#(
    parameter int unsigned LOCAL_X = 0,
    parameter int unsigned LOCAL_Y = 0
) (
    input  logic [3:0]           dest_x_i,
    input  logic [3:0]           dest_y_i,
    output logic [NUM_PORTS-1:0] route_o
);

    localparam logic [3:0] LX = LOCAL_X[3:0];
    localparam logic [3:0] LY = LOCAL_Y[3:0];

    always_comb begin
        route_o = '0;
        if (dest_x_i > LX) begin
            route_o[E] = 1'b1;
        end else if (dest_x_i < LX) begin
            route_o[W] = 1'b1;
        end else if (dest_y_i > LY) begin
            route_o[N] = 1'b1;
        end else if (dest_y_i < LY) begin
            route_o[S] = 1'b1;
        end else begin
            route_o[L] = 1'b1;
        end
    end

endmodule

// File: rtl/input_route_ctrl.sv
// Input-port controller: pops flits from the input buffer, XY-routes heads,
// requests and locks one output port until the tail (wormhole switching).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   buf_flit_i    : flit at buffer read pointer
//   buf_empty_i   : buffer empty
//   buf_pop_o     : pop buffer this cycle (combinational)
//   req_o         : registered one-hot output port request {L,W,S,E,N}
//   grant_i       : allocator grant, same cycle as req_o
//   out_on_i      : downstream on/off flow control, 1 = may send
//   flit_o        : registered flit to crossbar, holds when not valid
//   flit_valid_o  : flit_o valid
//   err_o         : sticky protocol error flag
module input_route_ctrl
    import router_pkg::*;
#(
    parameter int unsigned LOCAL_X = 0,
    parameter int unsigned LOCAL_Y = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [63:0]          buf_flit_i,
    input  logic                 buf_empty_i,
    output logic                 buf_pop_o,
    output logic [NUM_PORTS-1:0] req_o,
    input  logic                 grant_i,
    input  logic                 out_on_i,
    output logic [63:0]          flit_o,
    output logic                 flit_valid_o,
    output logic                 err_o
);

    ctrl_state_e          state_q, state_d;
    logic [NUM_PORTS-1:0] route_q, route_d;
    logic [NUM_PORTS-1:0] req_q, req_d;
    flit_t                flit_q, flit_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;
    logic [NUM_PORTS-1:0] xy_route;
    flit_type_e           head_type;
    flit_t                fwd_flit;
    logic                 pop;
    logic                 fwd;

    assign head_type = flit_type_e'(buf_flit_i[TYPE_HI:TYPE_LO]);

    xy_route_compute #(
        .LOCAL_X (LOCAL_X),
        .LOCAL_Y (LOCAL_Y)
    ) u_xy_route (
        .dest_x_i (buf_flit_i[DX_HI:DX_LO]),
        .dest_y_i (buf_flit_i[DY_HI:DY_LO]),
        .route_o  (xy_route)
    );

    always_comb begin
        state_d  = state_q;
        route_d  = route_q;
        err_d    = err_q;
        pop      = 1'b0;
        fwd      = 1'b0;
        fwd_flit = buf_flit_i;
        unique case (state_q)
            StIdle: begin
                if (!buf_empty_i) begin
                    if (head_type == FlitHead || head_type == FlitSingle) begin
                        route_d = xy_route;
                        state_d = StReq;
                    end else begin
                        // Orphan body/tail: drop it so the port cannot wedge.
                        pop   = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (grant_i && out_on_i && !buf_empty_i) begin
                    pop = 1'b1;
                    fwd = 1'b1;
                    if (head_type == FlitSingle) begin
                        state_d = StIdle;
                        route_d = '0;
                    end else begin
                        state_d = StActive;
                    end
                end
            end
            StActive: begin
                if (!buf_empty_i && out_on_i) begin
                    pop = 1'b1;
                    fwd = 1'b1;
                    unique case (head_type)
                        FlitTail: begin
                            state_d = StIdle;
                            route_d = '0;
                        end
                        FlitHead, FlitSingle: begin
                            // Stray head inside a packet: pass it as payload, keep the lock.
                            err_d                      = 1'b1;
                            fwd_flit[TYPE_HI:TYPE_LO]  = FlitBody;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Request follows the next state so it drops the cycle the FSM re-enters idle.
    assign req_d  = (state_d == StIdle) ? '0 : route_d;
    assign flit_d = fwd ? fwd_flit : flit_q;
    assign vld_d  = fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            route_q <= '0;
            req_q   <= '0;
            flit_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            req_q   <= req_d;
            flit_q  <= flit_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign buf_pop_o    = pop;
    assign req_o        = req_q;
    assign flit_o       = flit_q;
    assign flit_valid_o = vld_q;
    assign err_o        = err_q;

endmodule
